// File: rtl/rv_sb_regfile_pkg.sv
// Shared types for the scoreboarded register file: operand/address types,
// port structs and the init/run state encoding.
package RV_pkg;

   localparam int unsigned RV_XLEN = 32;
   localparam int unsigned RV_NREG = 32;
   localparam int unsigned RV_AW   = $clog2(RV_NREG);

   typedef logic [RV_XLEN-1:0] OperandType;
   typedef logic [RV_AW-1:0]   RegAddrType;

   typedef struct packed {
      logic       en;
      RegAddrType addr;
   } RegCtrlPortType;

   typedef struct packed {
      logic       en;
      RegAddrType addr;
      OperandType data;
   } RegWritePortType;

   typedef struct packed {
      OperandType data;
      logic       avail;
   } RegReadPortType;

   typedef enum logic {
      ST_INIT,
      ST_RUN
   } RfStateType;

endpackage

// File: rtl/rv_sb_regfile_scoreboard.sv
// Busy bit per architectural register; a set in the same cycle as a clear wins,
// so a newly issued producer is never lost to an older writeback.
module rv_reg_scoreboard #(
   parameter  int unsigned NREG    = 32,
   parameter  int unsigned NUM_CLR = 1,
   localparam int unsigned AW      = $clog2(NREG)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   set,
   input  logic [AW-1:0]          set_addr,
   input  logic [NUM_CLR-1:0]     clr,
   input  logic [NUM_CLR*AW-1:0]  clr_addr,
   output logic [NREG-1:0]        busy
);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy <= '0;
      end else begin
         for (int unsigned c = 0; c < NUM_CLR; c++) begin
            if (clr[c]) busy[clr_addr[c*AW +: AW]] <= 1'b0;
         end
         if (set) busy[set_addr] <= 1'b1;
      end
   end

endmodule

// File: rtl/rv_sb_regfile.sv
// Register file with operand scoreboard, writeback bypass and a post-reset
// clear sequence that zeroes one register per cycle before accepting issue.
module rv_sb_regfile
   import RV_pkg::*;
#(
   parameter  int unsigned NUM_RD = 2,
   parameter  int unsigned NUM_WB = 1,
   parameter  int unsigned XLEN   = RV_XLEN,
   parameter  int unsigned NREG   = RV_NREG,
   localparam int unsigned AW     = $clog2(NREG)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_RD-1:0]       rd_en,
   input  logic [NUM_RD*AW-1:0]    rd_addr,
   output logic [NUM_RD*XLEN-1:0]  rd_data,
   output logic [NUM_RD-1:0]       rd_avail,
   input  logic                    iss_valid,
   input  logic [AW-1:0]           iss_addr,
   input  logic [NUM_WB-1:0]       wb_en,
   input  logic [NUM_WB*AW-1:0]    wb_addr,
   input  logic [NUM_WB*XLEN-1:0]  wb_data,
   output logic                    ready
);

   RfStateType      state;
   RegAddrType      cnt;
   OperandType      regs [NREG];
   logic [NREG-1:0] busy;
   logic            run;
   logic [NUM_WB-1:0] clr;
   logic            set;

   RegCtrlPortType  rd_req [NUM_RD];
   RegReadPortType  rd_rsp [NUM_RD];
   RegWritePortType wb     [NUM_WB];

   assign run = (state == ST_RUN);
   assign set = run && iss_valid && (iss_addr != '0);

   for (genvar w = 0; w < NUM_WB; w++) begin : g_wb
      assign wb[w].en   = run && wb_en[w];
      assign wb[w].addr = wb_addr[w*AW +: AW];
      assign wb[w].data = wb_data[w*XLEN +: XLEN];
      assign clr[w]     = wb[w].en && (wb[w].addr != '0);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_INIT;
         cnt   <= RegAddrType'(1);
         ready <= 1'b0;
      end else if (state == ST_INIT) begin
         cnt <= cnt + 1'b1;
         if (cnt == RegAddrType'(NREG-1)) begin
            state <= ST_RUN;
            ready <= 1'b1;
         end
      end
   end

   // Array has no reset: contents are zeroed only by the INIT walk; x0 is never stored.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (state == ST_INIT) begin
            regs[cnt] <= '0;
         end else begin
            for (int unsigned w = 0; w < NUM_WB; w++) begin
               if (clr[w]) regs[wb[w].addr] <= wb[w].data;
            end
         end
      end
   end

   rv_reg_scoreboard #(
      .NREG    (NREG),
      .NUM_CLR (NUM_WB)
   ) u_scoreboard (
      .clk      (clk),
      .rst_n    (rst_n),
      .set      (set),
      .set_addr (iss_addr),
      .clr      (clr),
      .clr_addr (wb_addr),
      .busy     (busy)
   );

   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      assign rd_req[p].en   = rd_en[p];
      assign rd_req[p].addr = rd_addr[p*AW +: AW];

      // Later assignments override earlier ones: higher wb port beats lower, x0 beats all.
      always_comb begin
         rd_rsp[p].data  = regs[rd_req[p].addr];
         rd_rsp[p].avail = !(busy[rd_req[p].addr] && rd_req[p].en);
         for (int unsigned w = 0; w < NUM_WB; w++) begin
            if (wb[w].en && (wb[w].addr == rd_req[p].addr)) begin
               rd_rsp[p].data  = wb[w].data;
               rd_rsp[p].avail = 1'b1;
            end
         end
         if (rd_req[p].addr == '0) begin
            rd_rsp[p].data  = '0;
            rd_rsp[p].avail = 1'b1;
         end
         if (!run) rd_rsp[p].avail = 1'b0;
      end

      assign rd_data[p*XLEN +: XLEN] = rd_rsp[p].data;
      assign rd_avail[p]             = rd_rsp[p].avail;
   end

endmodule

// File: tb/tb_rv_sb_regfile.sv
// Directed scenarios followed by randomized traffic, all compared against an
// array-based model of the register file and its busy bits.
module tb_rv_sb_regfile;

   localparam int NRD = 2;
   localparam int NWB = 2;
   localparam int NR  = 32;
   localparam int AW  = 5;
   localparam int XL  = 32;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NRD-1:0]    rd_en;
   logic [NRD*AW-1:0] rd_addr;
   logic [NRD*XL-1:0] rd_data;
   logic [NRD-1:0]    rd_avail;
   logic              iss_valid;
   logic [AW-1:0]     iss_addr;
   logic [NWB-1:0]    wb_en;
   logic [NWB*AW-1:0] wb_addr;
   logic [NWB*XL-1:0] wb_data;
   logic              ready;

   int errors = 0;
   int checks = 0;

   logic [31:0] m_regs [NR];
   bit          m_busy [NR];
   int          m_icnt;
   bit          m_run;

   always #10 clk = ~clk;

   rv_sb_regfile #(
      .NUM_RD (NRD),
      .NUM_WB (NWB),
      .XLEN   (XL),
      .NREG   (NR)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .rd_avail  (rd_avail),
      .iss_valid (iss_valid),
      .iss_addr  (iss_addr),
      .wb_en     (wb_en),
      .wb_addr   (wb_addr),
      .wb_data   (wb_data),
      .ready     (ready)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic idle();
      rd_en     = '0;
      rd_addr   = '0;
      iss_valid = 1'b0;
      iss_addr  = '0;
      wb_en     = '0;
      wb_addr   = '0;
      wb_data   = '0;
   endtask

   task automatic set_rd(input int p, input logic en, input int a);
      rd_en[p]             = en;
      rd_addr[p*AW +: AW]  = AW'(a);
   endtask

   task automatic set_wb(input int w, input int a, input logic [31:0] d);
      wb_en[w]             = 1'b1;
      wb_addr[w*AW +: AW]  = AW'(a);
      wb_data[w*XL +: XL]  = d;
   endtask

   task automatic expect_rd(input string tag, input int p, input logic [31:0] d, input logic v);
      check({tag, "_data"}, rd_data[p*XL +: XL], d);
      check({tag, "_avail"}, 32'(rd_avail[p]), 32'(v));
   endtask

   // Operand value: x0 is zero; otherwise the newest writeback this cycle if any,
   // else the stored value, unavailable only when pending and actually requested.
   task automatic compare_model();
      int          a;
      logic [31:0] d;
      logic        v;
      check("ready", 32'(ready), 32'(m_run));
      for (int p = 0; p < NRD; p++) begin
         a = int'(rd_addr[p*AW +: AW]);
         if (!m_run) begin
            check($sformatf("avail_init%0d", p), 32'(rd_avail[p]), 32'd0);
         end else begin
            d = m_regs[a];
            v = !(m_busy[a] && rd_en[p]);
            for (int w = 0; w < NWB; w++) begin
               if (wb_en[w] && int'(wb_addr[w*AW +: AW]) == a) begin
                  d = wb_data[w*XL +: XL];
                  v = 1'b1;
               end
            end
            if (a == 0) begin
               d = '0;
               v = 1'b1;
            end
            check($sformatf("rd_data%0d", p), rd_data[p*XL +: XL], d);
            check($sformatf("rd_avail%0d", p), 32'(rd_avail[p]), 32'(v));
         end
      end
   endtask

   task automatic model_update();
      int a;
      if (!rst_n) begin
         m_icnt = 0;
         m_run  = 1'b0;
         foreach (m_busy[i]) m_busy[i] = 1'b0;
      end else if (!m_run) begin
         m_regs[m_icnt + 1] = '0;
         m_icnt++;
         if (m_icnt == NR - 1) m_run = 1'b1;
      end else begin
         for (int w = 0; w < NWB; w++) begin
            a = int'(wb_addr[w*AW +: AW]);
            if (wb_en[w] && a != 0) begin
               m_regs[a] = wb_data[w*XL +: XL];
               m_busy[a] = 1'b0;
            end
         end
         if (iss_valid && iss_addr != '0) m_busy[iss_addr] = 1'b1;
      end
   endtask

   task automatic tick();
      #2;
      compare_model();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   initial begin
      foreach (m_regs[i]) m_regs[i] = '0;
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      m_icnt = 0;
      m_run  = 1'b0;
      idle();
      rst_n = 1'b0;
      @(posedge clk);
      model_update();
      @(negedge clk);
      tick();

      // Clear sequence: ready low for NREG-1 cycles, then high.
      rst_n = 1'b1;
      set_rd(0, 1'b1, 5);
      for (int i = 0; i < NR - 1; i++) begin
         #1 check("ready_during_init", 32'(ready), 32'd0);
         tick();
      end
      #1 check("ready_after_init", 32'(ready), 32'd1);
      expect_rd("x5_after_init", 0, 32'h0, 1'b1);
      tick();

      idle(); iss_valid = 1'b1; iss_addr = 5'd7; tick();
      idle(); set_rd(0, 1'b1, 7);
      #1 expect_rd("x7_busy", 0, 32'h0, 1'b0);
      tick();
      idle(); set_rd(0, 1'b1, 7); set_wb(0, 7, 32'hDEADBEEF);
      #1 expect_rd("x7_bypass", 0, 32'hDEADBEEF, 1'b1);
      tick();
      idle(); set_rd(0, 1'b1, 7);
      #1 expect_rd("x7_stored", 0, 32'hDEADBEEF, 1'b1);
      tick();

      idle(); iss_valid = 1'b1; iss_addr = 5'd9; set_wb(0, 9, 32'h11); tick();
      idle(); set_rd(1, 1'b1, 9);
      #1 expect_rd("x9_iss_wb", 1, 32'h11, 1'b0);
      tick();

      idle(); set_wb(0, 3, 32'hA); set_wb(1, 3, 32'hB); set_rd(1, 1'b1, 3);
      #1 expect_rd("x3_dual_bypass", 1, 32'hB, 1'b1);
      tick();
      idle(); set_rd(0, 1'b1, 3);
      #1 expect_rd("x3_dual_stored", 0, 32'hB, 1'b1);
      tick();

      idle(); set_wb(0, 0, 32'hFF); iss_valid = 1'b1; iss_addr = 5'd0; set_rd(0, 1'b1, 0);
      #1 expect_rd("x0_same", 0, 32'h0, 1'b1);
      tick();
      idle(); set_rd(0, 1'b1, 0); set_rd(1, 1'b1, 0);
      #1 expect_rd("x0_after", 1, 32'h0, 1'b1);
      tick();

      idle(); set_wb(0, 4, 32'h55); tick();
      idle(); iss_valid = 1'b1; iss_addr = 5'd4; tick();
      idle(); set_rd(0, 1'b1, 4);
      #1 expect_rd("x4_busy", 0, 32'h55, 1'b0);
      tick();
      idle(); rst_n = 1'b0; tick();
      rst_n = 1'b1; set_rd(0, 1'b1, 4);
      #1 check("ready_dropped", 32'(ready), 32'd0);
      for (int i = 0; i < NR - 1; i++) tick();
      #1 check("ready_reinit", 32'(ready), 32'd1);
      expect_rd("x4_reinit", 0, 32'h0, 1'b1);
      tick();

      for (int n = 0; n < 800; n++) begin
         idle();
         rst_n = ($urandom_range(0, 199) != 0);
         for (int p = 0; p < NRD; p++)
            set_rd(p, 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7)));
         iss_valid = 1'($urandom_range(0, 1));
         iss_addr  = AW'($urandom_range(0, 7));
         for (int w = 0; w < NWB; w++)
            if ($urandom_range(0, 1) == 1) set_wb(w, int'($urandom_range(0, 7)), $urandom);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rv_sb_regfile.md
RV_SB_REGFILE -- requirements
Module: rv_sb_regfile

Interface
REQ-001 Parameter NUM_RD, 2, number of read ports (1..4).
REQ-002 Parameter NUM_WB, 1, number of writeback ports (1..2).
REQ-003 Parameter XLEN, 32, register data width.
REQ-004 Parameter NREG, 32, architectural registers (power of 2); AW = log2(NREG).
REQ-005 clk  input  1  single clock; all state updates on posedge clk.
REQ-006 rst_n  input  1  reset, synchronous and active-low.
REQ-007 rd_en  input  NUM_RD  per-port read request; operand is needed.
REQ-008 rd_addr  input  NUM_RD x AW  per-port source register.
REQ-009 rd_data  output  NUM_RD x XLEN  per-port operand value.
REQ-010 rd_avail  output  NUM_RD  per-port operand valid this cycle.
REQ-011 iss_valid  input  1  instruction issued with a destination register.
REQ-012 iss_addr  input  AW  issued destination register; it is marked busy.
REQ-013 wb_en  input  NUM_WB  per-port writeback valid.
REQ-014 wb_addr  input  NUM_WB x AW  per-port writeback register.
REQ-015 wb_data  input  NUM_WB x XLEN  per-port writeback value.
REQ-016 ready  output  1  initialisation complete; issue is accepted.

Function
REQ-017 Two-state FSM, INIT and RUN; reset enters INIT with init counter = 1.
REQ-018 In INIT, one register per cycle (counter address) is written 0 and its busy bit cleared; the counter increments.
REQ-019 INIT -> RUN in the cycle after register NREG-1 is cleared, so ready rises exactly NREG-1 cycles after rst_n deasserts.
REQ-020 In INIT: ready=0, rd_avail=0 on every port, and iss_valid and wb_en are ignored.
REQ-021 In RUN: ready=1, and the FSM stays in RUN until reset.
REQ-022 Register 0 always reads 0 with rd_avail=1; it is never written and never marked busy.
REQ-023 Read is combinational (zero latency) with the following priority: addr 0; then a matching wb_en port (bypass wb_data, avail=1); then a busy register (data = array value, avail = !rd_en); else the array value with avail=1.
REQ-024 If both wb ports match a read address, the higher-index port supplies the data.
REQ-025 A writeback in RUN writes the array at the next posedge and clears busy[wb_addr].
REQ-026 A same-address write on both wb ports stores the higher-index port's data.
REQ-027 iss_valid in RUN with iss_addr != 0 sets busy[iss_addr] at the next posedge.
REQ-028 If issue and writeback target the same register in the same cycle, the array is written and busy stays set (new producer wins).
REQ-029 Issue to an already-busy register (WAW) is accepted and the register stays busy.
REQ-030 A writeback to a non-busy register is legal; the array is written and busy remains 0.

Reset
REQ-031 rst_n=0 sampled at posedge: FSM=INIT, counter=1, all busy bits = 0, ready=0 from the following cycle.
REQ-032 Reset asserted mid-INIT or mid-RUN restarts the full clear sequence; in-flight busy state is discarded.
REQ-033 The register array is cleared only by the INIT sequence, with no reset-time bulk clear.

Structure
REQ-034 OperandType, RegAddrType, RegCtrlPortType, RegWritePortType and RegReadPortType live in RV_pkg; the FSM state enum is added to RV_pkg.
REQ-035 Read and writeback ports are arrays of the RV_pkg struct types sized by NUM_RD and NUM_WB.
REQ-036 The busy-bit vector with its set/clear priority is a sub-module, rv_reg_scoreboard (ports: clk, rst_n, set, set_addr, clr, clr_addr, busy).

Verification
REQ-037 Release reset -> ready=0 for 31 cycles, ready=1 on cycle 32; a read of x5 with rd_en=1 returns 0, avail=1.
REQ-038 Issue x7, then read x7 with rd_en=1 -> avail=0; next cycle wb x7=0xDEADBEEF -> same-cycle read returns 0xDEADBEEF, avail=1; the cycle after returns it from the array, avail=1.
REQ-039 Same cycle: iss x9 and wb x9=0x11 -> next-cycle read of x9: data 0x11, avail=0 (rd_en=1).
REQ-040 NUM_WB=2, both ports write x3 with 0xA and 0xB -> bypass and stored value are both 0xB.
REQ-041 Write x0=0xFF and issue x0 -> a read of x0 gives 0, avail=1.
REQ-042 Assert rst_n=0 for 1 cycle while x4=0x55 is busy -> ready drops; after re-init x4 reads 0, avail=1.
